pipe_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake on both sides. The WIDTH-bit datapath is split into STAGES equal slices. Each slice is a ripple-carry adder, and the carry between slices is registered. Throughput is one operation per clock, and latency is STAGES cycles. It replaces fixed-width combinational ripple adders on wide arithmetic paths where a single-cycle carry chain misses timing.

---
 rtl/pipe_adder_pkg.sv | 13 +
 rtl/add_slice.sv | 29 ++
 rtl/pipe_adder.sv | 127 ++++++++++++
 tb/tb_pipe_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined adder: slice-width computation and the
// WIDTH/STAGES legality rule checked when the top level elaborates.
package pipe_adder_pkg;

  function automatic int cw(input int width, input int stages);
    return (stages > 32'sd0) ? (width / stages) : width;
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (stages >= 32'sd1) && (stages <= width) && ((width % stages) == 32'sd0);
  endfunction

endpackage

// File: rtl/add_slice.sv
// CW-bit ripple-carry adder used as one pipeline slice of pipe_adder.
module add_slice
  import pipe_adder_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co
);

  logic [CW:0] c_s;

  // bit-serial carry chain across the slice
  always_comb begin
    c_s    = {(CW + 1){1'b0}};
    s      = {CW{1'b0}};
    c_s[0] = ci;
    for (int i = 0; i < CW; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c_s[CW];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one ripple slice per stage, registered inter-slice
// carry, skewed operands and deskewed sums, global stall on output backpressure.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW  = cw(WIDTH, STAGES);
  localparam int TOP = STAGES - 1;
  localparam logic [WIDTH-1:0] SLICE_ONES = WIDTH'({CW{1'b1}});

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic                           adv_s;
  logic [WIDTH-1:0]               b_eff_s;
  logic                           c0_s;

  logic [STAGES-1:0]              valid_r;
  logic [STAGES-1:0][WIDTH-1:0]   a_r;
  logic [STAGES-1:0][WIDTH-1:0]   b_r;
  logic [STAGES-1:0][WIDTH-1:0]   s_r;
  logic [STAGES-1:0]              c_r;
  logic                           ovf_r;

  logic [STAGES-1:0][WIDTH-1:0]   a_src_s;
  logic [STAGES-1:0][WIDTH-1:0]   b_src_s;
  logic [STAGES-1:0][WIDTH-1:0]   s_src_s;
  logic [STAGES-1:0][WIDTH-1:0]   s_nxt_s;
  logic [STAGES-1:0][CW-1:0]      slice_s;
  logic [STAGES-1:0]              c_src_s;
  logic [STAGES-1:0]              c_nxt_s;
  logic                           ovf_nxt_s;
  logic                           unused_s;

  // A full output blocks the whole pipe; there is no bubble collapsing.
  assign adv_s    = !valid_r[TOP] || out_ready;
  assign in_ready = adv_s;

  assign b_eff_s = sub ? ~b : b;
  assign c0_s    = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_src_s[k] = a;
      assign b_src_s[k] = b_eff_s;
      assign c_src_s[k] = c0_s;
      assign s_src_s[k] = {WIDTH{1'b0}};
    end else begin : g_next
      assign a_src_s[k] = a_r[k-1];
      assign b_src_s[k] = b_r[k-1];
      assign c_src_s[k] = c_r[k-1];
      assign s_src_s[k] = s_r[k-1];
    end

    add_slice #(.CW(CW)) u_slice (
      .a  (a_src_s[k][k*CW +: CW]),
      .b  (b_src_s[k][k*CW +: CW]),
      .ci (c_src_s[k]),
      .s  (slice_s[k]),
      .co (c_nxt_s[k])
    );

    assign s_nxt_s[k] = (s_src_s[k] & ~(SLICE_ONES << (k * CW)))
                      | (WIDTH'(slice_s[k]) << (k * CW));
  end

  // Sign rule on the effective operand B', evaluated where the top slice completes.
  assign ovf_nxt_s = (a_src_s[TOP][WIDTH-1] == b_src_s[TOP][WIDTH-1])
                  && (s_nxt_s[TOP][WIDTH-1] != a_src_s[TOP][WIDTH-1]);

  // The last stage's skew copy is never consumed further down the pipe.
  assign unused_s = ^{a_r[TOP], b_r[TOP]};

  // stage registers advance together; stage 0 samples inputs only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {STAGES{1'b0}};
      a_r     <= {(STAGES * WIDTH){1'b0}};
      b_r     <= {(STAGES * WIDTH){1'b0}};
      s_r     <= {(STAGES * WIDTH){1'b0}};
      c_r     <= {STAGES{1'b0}};
      ovf_r   <= 1'b0;
    end else if (adv_s) begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        a_r[0] <= a_src_s[0];
        b_r[0] <= b_src_s[0];
        s_r[0] <= s_nxt_s[0];
        c_r[0] <= c_nxt_s[0];
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_r[k] <= valid_r[k-1];
        a_r[k]     <= a_src_s[k];
        b_r[k]     <= b_src_s[k];
        s_r[k]     <= s_nxt_s[k];
        c_r[k]     <= c_nxt_s[k];
      end
      if ((TOP != 0) || in_valid) begin
        ovf_r <= ovf_nxt_s;
      end
    end
  end

  assign out_valid = valid_r[TOP];
  assign sum       = s_r[TOP];
  assign cout      = c_r[TOP];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench: four pipe_adder instances (STAGES 4,1,2,16) against an
// arithmetic reference model with per-instance scoreboards.
module tb_pipe_adder;

  localparam int W = 16;
  localparam int N = 4;
  localparam int SV [N] = '{4, 1, 2, 16};

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [31:0] acc;
    logic [31:0] stl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, out_ready, cin, sub;
  logic [15:0]   a, b;
  logic [N-1:0]  en, iv, ir, ov, co, of;
  logic [15:0]   sm [N];

  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  exp_t          q [N][$];
  logic          hold [N];
  logic [15:0]   hsum [N];
  logic          hco [N];
  logic          hof [N];
  int            stl [N];
  int            emitted [N];

  assign iv = {N{in_valid}} & en;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < N; i++) begin : g_dut
    pipe_adder #(.WIDTH(W), .STAGES(SV[i])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[i]),
      .in_ready  (ir[i]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov[i]),
      .out_ready (out_ready),
      .sum       (sm[i]),
      .cout      (co[i]),
      .ovf       (of[i])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, overflow as signed range violation.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tc, input logic ts);
    exp_t e;
    int r;
    logic [16:0] full;
    e = '0;
    if (ts) begin
      full   = {1'b0, ta} - {1'b0, tb};
      r      = int'($signed(ta)) - int'($signed(tb));
      e.cout = (ta >= tb);
    end else begin
      full   = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
      r      = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
      e.cout = full[16];
    end
    e.sum = full[15:0];
    e.ovf = (r > 32767) || (r < -32768);
    return e;
  endfunction

  // Compare process: handshake events are judged at the negedge before the edge.
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      hold[i] = 1'b0; stl[i] = 0; emitted[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          q[i].delete();
          hold[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (hold[i]) begin
            check($sformatf("s%0d_hold_valid", SV[i]), 32'(ov[i]), 32'd1);
            check($sformatf("s%0d_hold_sum", SV[i]), 32'(sm[i]), 32'(hsum[i]));
            check($sformatf("s%0d_hold_cout", SV[i]), 32'(co[i]), 32'(hco[i]));
            check($sformatf("s%0d_hold_ovf", SV[i]), 32'(of[i]), 32'(hof[i]));
          end
          check($sformatf("s%0d_in_ready", SV[i]), 32'(ir[i]), 32'(!ov[i] || out_ready));
          if (ov[i] && !out_ready) begin
            hold[i] = 1'b1; hsum[i] = sm[i]; hco[i] = co[i]; hof[i] = of[i];
            stl[i]++;
          end else begin
            hold[i] = 1'b0;
          end
          if (ov[i] && out_ready) begin
            check($sformatf("s%0d_emit_has_item", SV[i]), 32'(q[i].size() != 0), 32'd1);
            if (q[i].size() != 0) begin
              e = q[i].pop_front();
              emitted[i]++;
              check($sformatf("s%0d_sum", SV[i]), 32'(sm[i]), 32'(e.sum));
              check($sformatf("s%0d_cout", SV[i]), 32'(co[i]), 32'(e.cout));
              check($sformatf("s%0d_ovf", SV[i]), 32'(of[i]), 32'(e.ovf));
              if (e.stl == 32'(stl[i]))
                check($sformatf("s%0d_latency", SV[i]), 32'(cyc + 1) - e.acc, 32'(SV[i]));
            end
          end
          if (iv[i] && ir[i]) begin
            e = model(a, b, cin, sub);
            e.acc = 32'(cyc + 1);
            e.stl = 32'(stl[i]);
            q[i].push_back(e);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
    bit ok;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ir[0]) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic directed(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts,
                          input logic [15:0] es, input logic ec, input logic eo);
    int k;
    send(ta, tb, tc, ts);
    in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!ov[0] && k < 20);
    check({nm, "_latency"}, 32'(k), 32'd4);
    check({nm, "_sum"}, 32'(sm[0]), 32'(es));
    check({nm, "_cout"}, 32'(co[0]), 32'(ec));
    check({nm, "_ovf"}, 32'(of[0]), 32'(eo));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit empty;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) empty = 1'b0;
      if (empty) break;
    end
    for (int i = 0; i < N; i++)
      check($sformatf("s%0d_drained", SV[i]), 32'(q[i].size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int e0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0; en = 4'b0001;
    #12;
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_sum", 32'(sm[0]), 32'd0);
    check("rst_cout", 32'(co[0]), 32'd0);
    check("rst_ovf", 32'(of[0]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(ir[0]), 32'd1);
    @(posedge clk); #1;

    directed("add_ff_01",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed("full_carry", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_cin",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("slice_edge", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    directed("mixed_sign", 16'h00FF, 16'hFF01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("neg_ovf",    16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // back-to-back stream with a 3-cycle output stall
    e0 = emitted[0];
    fork
      begin
        for (int j = 0; j < 8; j++)
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 32'(emitted[0] - e0), 32'd8);

    // asynchronous reset with three items in flight
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h2345, 16'h1111, 1'b0, 1'b0);
    send(16'h3456, 16'h1111, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_valid", 32'(ov[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ov[0]), 32'd0);
    check("async_rst_sum", 32'(sm[0]), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("no_stale", 32'(ov[0]), 32'd0);
    end
    @(posedge clk); #1;
    directed("post_rst", 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);

    // mixed add/sub sweep on all depths, with random bubbles
    en = 4'b1111;
    for (int j = 0; j < 1000; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
